instr_sequencer: RTL
====================

Name: instr_sequencer

Overview:
Multi-cycle fetch/decode/execute controller for the two-accumulator 8-bit core.
- Owns the 10-bit program counter and the 16-bit instruction register.
- Fetches from instruction memory and feeds the registered instruction decoder.
- Sequences data-memory access and writeback, and applies jump/branch control returned by the decoder.
- Enforces request/acknowledge handshakes with a bounded-wait timeout.

Parameters:
PC_W, 10, program counter / instruction address width
IR_W, 16, instruction width
BR_W, 6, branch offset width (two's complement)
RESET_PC, 0, PC value loaded at reset
ACK_TIMEOUT, 15, max cycles a req may wait for ack before error (1..255)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
run  in  1  1 = execute; 0 = stop at next instruction boundary
imem_req  out  1  instruction fetch request
imem_addr  out  PC_W  fetch address (= pc)
imem_ack  in  1  fetch data valid
imem_data  in  IR_W  fetched instruction
ir  out  IR_W  instruction register, drives decoder input
exe_en  out  1  one-cycle execute strobe to datapath
jmp_en  in  1  decoder jump enable
branch_en  in  1  decoder branch-taken enable
jmp_dir  in  PC_W  absolute jump target
branch_dir  in  BR_W  signed branch offset
mem_rd  in  1  decoded instruction reads data memory
mem_wr  in  1  decoded instruction writes data memory
dmem_req  out  1  data memory request
dmem_we  out  1  data memory write qualifier
dmem_ack  in  1  data memory complete
wb_en  out  1  one-cycle register writeback strobe
pc  out  PC_W  current program counter
busy  out  1  high in any state except IDLE and ERR
err  out  1  sticky handshake-timeout flag

Behaviour:
Reset (reset=0, async):
- State = IDLE; pc = RESET_PC; ir = 0.
- All strobes, requests, busy, err = 0; timeout counter = 0.

States:
- IDLE: wait for run=1, then go to FETCH.
- FETCH: imem_req=1, held stable until an ack is sampled.
  - imem_ack=1 (legal in the first req cycle): ir <= imem_data, go to DECODE.
- DECODE: one cycle; the decoder registers its controls from ir. No outputs change.
- EXEC: exe_en=1 for exactly one cycle; jmp_en, branch_en, mem_rd, mem_wr, jmp_dir, branch_dir are sampled here.
  - mem_rd or mem_wr: go to MEM.
  - Otherwise: go to WB.
- MEM: dmem_req=1, dmem_we = registered mem_wr (EXEC sample), both held until dmem_ack=1, then go to WB.
  - mem_rd and mem_wr both set: treated as a write.
- WB: wb_en=1 for one cycle, except for pure stores, where wb_en=0. pc is updated. Then:
  - run=1: go to FETCH.
  - run=0: go to IDLE.
- ERR: all requests and strobes = 0; err=1. Leaves ERR only on reset.

PC update in WB, priority jmp > branch > increment:
- jmp_en: pc <= jmp_dir.
- branch_en: pc <= pc + 1 + sign_extend(branch_dir), modulo 2^PC_W.
- Otherwise: pc <= pc + 1.
- Wrap rules: 1023 + 1 = 0; pc = 2 with offset -4 gives 1023.

Timeout:
- Counter clears on entry to FETCH or MEM and increments each cycle the ack is low.
- When counter = ACK_TIMEOUT with ack still low: drop the request, go to ERR.
- An ack arriving in that same cycle wins (normal progress).

Handshake edge cases:
- imem_ack or dmem_ack while the matching req is low is ignored.
- run deasserted mid-instruction: the instruction completes; the stop is taken only at WB.
- Reset mid-handshake: req drops asynchronously.

Latency:
- Non-memory instruction: 4 cycles (FETCH with immediate ack, DECODE, EXEC, WB).
- Memory instruction: +1 cycle per MEM wait cycle.

Decomposition:
- Shared package/def header: state encoding (IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, ERR=6, 3 bits) and default parameter constants.
- Natural sub-module: pc_next_calc, a combinational next-PC selector implementing the jump/branch/increment priority and sign extension.
- The FSM, ir register and timeout counter stay in the top module.

Test Plan:
- Reset, run=1, imem_ack immediate, imem_data=16'h1234, no control inputs set -> ir=16'h1234 after FETCH; exe_en pulses exactly at cycle 3; wb_en at cycle 4; pc 0->1.
- Jump: jmp_en=1 and branch_en=1, jmp_dir=10'h3F0, branch_dir=6'h05, pc=7 -> jump priority applies, pc=10'h3F0.
- Branch wrap: pc=2, branch_en=1, branch_dir=6'b111100 (-4) -> pc=1023. Branch at pc=1023 with offset 0 -> pc=0.
- Store: mem_wr=1, dmem_ack held low 3 cycles then high -> dmem_req and dmem_we high 4 cycles, wb_en=0, pc+1.
- Timeout: imem_ack never asserted, ACK_TIMEOUT=15 -> imem_req drops after 15 low-ack cycles, err=1, busy=0. Stays in ERR until reset=0.
- Async reset asserted mid-MEM -> dmem_req=0 immediately, pc=RESET_PC, err=0. After release with run=0, stays IDLE.

Source files
------------

// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: FSM state encoding and
// default parameter values.
package instr_sequencer_pkg;

    localparam int PC_W_DEF        = 10;
    localparam int IR_W_DEF        = 16;
    localparam int BR_W_DEF        = 6;
    localparam int RESET_PC_DEF    = 0;
    localparam int ACK_TIMEOUT_DEF = 15;
    // Wide enough for the largest allowed timeout (255).
    localparam int TO_CNT_W        = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_ERR    = 3'd6
    } state_e;

endpackage

// File: rtl/instr_sequencer_pc_next_calc.sv
// Combinational next-PC selector: absolute jump beats relative branch, which
// beats sequential increment. All arithmetic wraps modulo 2^PC_W.
module instr_sequencer_pc_next_calc #(
    parameter int PC_W = 10,
    parameter int BR_W = 6
) (
    input  logic [PC_W-1:0] pc,
    input  logic            jmp_en,
    input  logic            branch_en,
    input  logic [PC_W-1:0] jmp_dir,
    input  logic [BR_W-1:0] branch_dir,
    output logic [PC_W-1:0] pc_next
);

    logic [PC_W-1:0] offset_ext;

    always_comb begin
        // Size cast of a signed value sign-extends the branch offset.
        offset_ext = PC_W'(signed'(branch_dir));
        if (jmp_en) begin
            pc_next = jmp_dir;
        end else if (branch_en) begin
            pc_next = pc + PC_W'(1) + offset_ext;
        end else begin
            pc_next = pc + PC_W'(1);
        end
    end

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/decode/execute controller: owns pc and ir, runs the instruction and
// data memory handshakes with a bounded wait, and applies jump/branch control.
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int PC_W        = PC_W_DEF,
    parameter int IR_W        = IR_W_DEF,
    parameter int BR_W        = BR_W_DEF,
    parameter int RESET_PC    = RESET_PC_DEF,
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            run,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [IR_W-1:0] imem_data,
    output logic [IR_W-1:0] ir,
    output logic            exe_en,
    input  logic            jmp_en,
    input  logic            branch_en,
    input  logic [PC_W-1:0] jmp_dir,
    input  logic [BR_W-1:0] branch_dir,
    input  logic            mem_rd,
    input  logic            mem_wr,
    output logic            dmem_req,
    output logic            dmem_we,
    input  logic            dmem_ack,
    output logic            wb_en,
    output logic [PC_W-1:0] pc,
    output logic            busy,
    output logic            err
);

    localparam logic [TO_CNT_W-1:0] ACK_LIMIT = TO_CNT_W'(ACK_TIMEOUT);

    state_e                state_q, state_d;
    logic [PC_W-1:0]       pc_q, pc_d;
    logic [IR_W-1:0]       ir_q, ir_d;
    logic [TO_CNT_W-1:0]   cnt_q, cnt_d;
    logic                  jmp_q, jmp_d;
    logic                  br_q, br_d;
    logic [PC_W-1:0]       jdir_q, jdir_d;
    logic [BR_W-1:0]       bdir_q, bdir_d;
    logic                  is_mem_q, is_mem_d;
    logic                  is_wr_q, is_wr_d;
    logic [PC_W-1:0]       pc_next;

    instr_sequencer_pc_next_calc #(
        .PC_W (PC_W),
        .BR_W (BR_W)
    ) u_pc_next_calc (
        .pc         (pc_q),
        .jmp_en     (jmp_q),
        .branch_en  (br_q),
        .jmp_dir    (jdir_q),
        .branch_dir (bdir_q),
        .pc_next    (pc_next)
    );

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        cnt_d    = cnt_q;
        jmp_d    = jmp_q;
        br_d     = br_q;
        jdir_d   = jdir_q;
        bdir_d   = bdir_q;
        is_mem_d = is_mem_q;
        is_wr_d  = is_wr_q;
        imem_req = 1'b0;
        exe_en   = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        wb_en    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (run) begin
                    state_d = ST_FETCH;
                    cnt_d   = '0;
                end
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                // A late ack in the limit cycle still counts as success.
                if (imem_ack) begin
                    ir_d    = imem_data;
                    state_d = ST_DECODE;
                end else if (cnt_q == ACK_LIMIT) begin
                    state_d = ST_ERR;
                end else begin
                    cnt_d = cnt_q + TO_CNT_W'(1);
                end
            end
            ST_DECODE: state_d = ST_EXEC;
            ST_EXEC: begin
                exe_en   = 1'b1;
                jmp_d    = jmp_en;
                br_d     = branch_en;
                jdir_d   = jmp_dir;
                bdir_d   = branch_dir;
                is_mem_d = mem_rd | mem_wr;
                is_wr_d  = mem_wr;
                if (mem_rd | mem_wr) begin
                    state_d = ST_MEM;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = is_wr_q;
                if (dmem_ack) begin
                    state_d = ST_WB;
                end else if (cnt_q == ACK_LIMIT) begin
                    state_d = ST_ERR;
                end else begin
                    cnt_d = cnt_q + TO_CNT_W'(1);
                end
            end
            ST_WB: begin
                // Any store (including read+write) has nothing to write back.
                wb_en = ~(is_mem_q & is_wr_q);
                pc_d  = pc_next;
                cnt_d = '0;
                state_d = run ? ST_FETCH : ST_IDLE;
            end
            ST_ERR:  state_d = ST_ERR;
            default: state_d = ST_ERR;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            pc_q     <= PC_W'(RESET_PC);
            ir_q     <= '0;
            cnt_q    <= '0;
            jmp_q    <= 1'b0;
            br_q     <= 1'b0;
            jdir_q   <= '0;
            bdir_q   <= '0;
            is_mem_q <= 1'b0;
            is_wr_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            cnt_q    <= cnt_d;
            jmp_q    <= jmp_d;
            br_q     <= br_d;
            jdir_q   <= jdir_d;
            bdir_q   <= bdir_d;
            is_mem_q <= is_mem_d;
            is_wr_q  <= is_wr_d;
        end
    end

    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign ir        = ir_q;
    assign busy      = (state_q != ST_IDLE) && (state_q != ST_ERR);
    assign err       = (state_q == ST_ERR);

endmodule
